// File: rtl/seg7_pkg.sv
// seg7_pkg: active-low 7-segment patterns (bit order a..g) shared by the decoders.
package seg7_pkg;
  typedef logic [0:6] seg7_t;
  localparam seg7_t SEG_0     = 7'b0000001;
  localparam seg7_t SEG_1     = 7'b1001111;
  localparam seg7_t SEG_2     = 7'b0010010;
  localparam seg7_t SEG_3     = 7'b0000110;
  localparam seg7_t SEG_4     = 7'b1001100;
  localparam seg7_t SEG_5     = 7'b0100100;
  localparam seg7_t SEG_6     = 7'b0100000;
  localparam seg7_t SEG_7     = 7'b0001111;
  localparam seg7_t SEG_8     = 7'b0000000;
  localparam seg7_t SEG_9     = 7'b0000100;
  localparam seg7_t SEG_BLANK = 7'b1111111;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD to active-low 7-segment; non-BCD codes blank the digit.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output seg7_t      display
);
  always_comb begin
    display = SEG_BLANK;
    case (bcd)
      4'd0: display = SEG_0;
      4'd1: display = SEG_1;
      4'd2: display = SEG_2;
      4'd3: display = SEG_3;
      4'd4: display = SEG_4;
      4'd5: display = SEG_5;
      4'd6: display = SEG_6;
      4'd7: display = SEG_7;
      4'd8: display = SEG_8;
      4'd9: display = SEG_9;
      default: display = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/clk_div_bcd7seg.sv
// clk_div_bcd7seg: divides the board clock to a TICK_HZ square wave plus rising-edge tick,
// and drives two 7-segment digits from BCD inputs.
module clk_div_bcd7seg
  import seg7_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1
) (
  input  logic       Clk_50MHz,
  input  logic       rst,
  output logic       Clk_1Hz,
  output logic       tick,
  input  logic [3:0] bcd0,
  input  logic [3:0] bcd1,
  output seg7_t      display0,
  output seg7_t      display1
);
  localparam int HALF = CLK_HZ / (2 * TICK_HZ);
  localparam int CW = HALF > 1 ? $clog2(HALF) : 1;
  if (HALF < 1) begin : g_bad_half
    $error("clk_div_bcd7seg: CLK_HZ/(2*TICK_HZ) must be at least 1");
  end
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);
  logic [CW-1:0] count_q, count_d;
  logic          clk_q, clk_d, tick_q, tick_d;
  logic          wrap;
  always_comb begin
    wrap    = count_q == LAST;
    count_d = wrap ? '0 : count_q + 1'b1;
    clk_d   = wrap ? ~clk_q : clk_q;
    tick_d  = wrap & ~clk_q;
  end
  always_ff @(posedge Clk_50MHz) begin
    if (rst) begin
      count_q <= '0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
    end
  end
  assign Clk_1Hz = clk_q;
  assign tick    = tick_q;
  seg7_decode u_dec0 (.bcd(bcd0), .display(display0));
  seg7_decode u_dec1 (.bcd(bcd1), .display(display1));
endmodule

// File: tb/tb_clk_div_bcd7seg.sv
// tb_clk_div_bcd7seg: random reset/BCD stimulus against a cycle-count reference model, HALF=5 and HALF=1.
module tb_clk_div_bcd7seg;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] bcd0, bcd1;
  logic       c5, t5, c1, t1;
  logic [0:6] d0_5, d1_5, d0_1, d1_1;
  int         checks = 0;
  int         errors = 0;
  int         n = 0;
  logic [0:6] seg_tab [16];
  clk_div_bcd7seg #(.CLK_HZ(10), .TICK_HZ(1)) u_dut5 (
    .Clk_50MHz(clk), .rst(rst), .Clk_1Hz(c5), .tick(t5),
    .bcd0(bcd0), .bcd1(bcd1), .display0(d0_5), .display1(d1_5)
  );
  clk_div_bcd7seg #(.CLK_HZ(2), .TICK_HZ(1)) u_dut1 (
    .Clk_50MHz(clk), .rst(rst), .Clk_1Hz(c1), .tick(t1),
    .bcd0(bcd0), .bcd1(bcd1), .display0(d0_1), .display1(d1_1)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask
  // n counts non-reset edges since the last reset; the square wave is high in odd HALF-blocks
  task automatic chk_div(input int h, input logic c, input logic t, input string tag);
    chk({tag, "_clk"}, {7'd0, c}, {7'd0, ((n / h) % 2) == 1});
    chk({tag, "_tick"}, {7'd0, t}, {7'd0, (n > 0) && (n % (2 * h) == h)});
  endtask
  task automatic chk_dec();
    chk("dec0_h5", {1'b0, d0_5}, {1'b0, seg_tab[bcd0]});
    chk("dec1_h5", {1'b0, d1_5}, {1'b0, seg_tab[bcd1]});
    chk("dec0_h1", {1'b0, d0_1}, {1'b0, seg_tab[bcd0]});
    chk("dec1_h1", {1'b0, d1_1}, {1'b0, seg_tab[bcd1]});
  endtask
  task automatic step(input logic r);
    @(posedge clk);
    n = rst ? 0 : n + 1;
    #1;
    chk_div(5, c5, t5, "h5");
    chk_div(1, c1, t1, "h1");
    rst  = r;
    bcd0 = 4'($urandom_range(0, 15));
    bcd1 = 4'($urandom_range(0, 15));
    #1;
    chk_dec();
  endtask
  initial begin
    seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100,
                7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
    rst  = 1'b1;
    bcd0 = 4'd8;
    bcd1 = 4'd0;
    #1;
    chk("dec_in_reset", {1'b0, d0_5}, {1'b0, 7'b0000000});
    for (int i = 0; i < 16; i++) begin
      bcd0 = 4'(i);
      bcd1 = 4'(15 - i);
      #1;
      chk_dec();
    end
    for (int i = 0; i < 3; i++) step(1'b1);
    for (int i = 0; i < 40; i++) step(1'b0);
    for (int i = 0; i < 6; i++) step(1'b0);
    step(1'b1);
    for (int i = 0; i < 20; i++) step(1'b0);
    for (int i = 0; i < 400; i++) step($urandom_range(0, 29) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
